// File: rtl/instr_fetch_queue_if.sv
// Fetch-unit bundle: instruction-memory request/grant/response channel plus the core-side queue head and redirect.
// master = fetch unit, slave = memory/core environment.
interface instr_fetch_queue_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              busy;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, busy,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, busy,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Sequential fetch into a DEPTH-entry in-order queue; head valid the edge after imem_rvalid.
// Requests stall when queue+outstanding or outstanding+drop credit runs out; a redirect flushes and drops in-flight data.
module instr_fetch_queue #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter int                MAX_OUT  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input logic                 clk,
  input logic                 rst,
  instr_fetch_queue_if.master bus
);
  localparam int QPW   = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int TPW   = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [CNT_W-1:0]  count;
  logic [QPW-1:0]    rd_ptr;
  logic [QPW-1:0]    wr_ptr;
  logic [OUT_W-1:0]  outstanding;
  logic [OUT_W-1:0]  drop;
  logic [TPW-1:0]    tag_rd;
  logic [TPW-1:0]    tag_wr;

  logic [DATA_W-1:0] q_word  [DEPTH];
  logic [ADDR_W-1:0] q_pc    [DEPTH];
  logic [ADDR_W-1:0] tag_mem [MAX_OUT];

  logic req_vld;
  logic head_vld;
  logic grant;
  logic resp_drop;
  logic resp_live;
  logic resp_ok;
  logic push;
  logic pop;

  function automatic logic [TPW-1:0] tag_inc(input logic [TPW-1:0] p);
    return (p == TPW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    req_vld   = !bus.redirect
                && ((SUM_W'(count) + SUM_W'(outstanding)) < SUM_W'(DEPTH))
                && ((SUM_W'(outstanding) + SUM_W'(drop)) < SUM_W'(MAX_OUT));
    head_vld  = (count != '0);
    grant     = req_vld && bus.imem_gnt;
    resp_drop = bus.imem_rvalid && (drop != '0);
    resp_live = bus.imem_rvalid && (drop == '0) && (outstanding != '0);
    resp_ok   = resp_drop || resp_live;
    push      = resp_live && !bus.redirect;
    pop       = head_vld && bus.instr_ready && !bus.redirect;
  end

  // rst only masks the port; internal state is held in reset anyway, so grant needs no gating.
  assign bus.imem_req    = rst && req_vld;
  assign bus.imem_addr   = fetch_pc;
  assign bus.instr_valid = head_vld;
  assign bus.instr       = head_vld ? q_word[rd_ptr] : '0;
  assign bus.instr_pc    = head_vld ? q_pc[rd_ptr] : '0;
  assign bus.busy        = (outstanding != '0) || (drop != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      outstanding <= '0;
      drop        <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
    end else begin
      // Tags track every issued request, dropped or live, so they pop on any accepted response.
      if (grant)   tag_wr <= tag_inc(tag_wr);
      if (resp_ok) tag_rd <= tag_inc(tag_rd);

      if (bus.redirect) begin
        fetch_pc    <= bus.redirect_pc;
        outstanding <= '0;
        drop        <= drop + outstanding - OUT_W'(resp_ok);
        count       <= '0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
      end else begin
        if (grant) fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
        outstanding <= outstanding + OUT_W'(grant) - OUT_W'(resp_live);
        drop        <= drop - OUT_W'(resp_drop);
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_word[wr_ptr] <= bus.imem_rdata;
      q_pc[wr_ptr]   <= tag_mem[tag_rd];
    end
    if (grant) tag_mem[tag_wr] <= fetch_pc;
  end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: memory model returns {24'b0, addr} after 'lat' cycles.
// Queue contents are checked in order against a locally stepped expected address.
module tb_instr_fetch_queue;
  logic       clk;
  logic       rst;
  int         lat;
  int         total;
  int         bad;
  logic [3:0] pv;
  logic [7:0] pa [4];
  int         live;
  int         max_live;

  instr_fetch_queue_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  instr_fetch_queue #(
    .ADDR_W(8), .DATA_W(32), .DEPTH(4), .MAX_OUT(4), .RESET_PC(8'h00), .PC_STEP(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.imem_rvalid = pv[lat-1];
  assign bus.imem_rdata  = {24'b0, pa[lat-1]};

  // Memory pipeline; resets with the DUT so no stale responses survive a reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv       <= '0;
      pa[0]    <= '0;
      pa[1]    <= '0;
      pa[2]    <= '0;
      pa[3]    <= '0;
      live     <= 0;
      max_live <= 0;
    end else begin
      pv    <= {pv[2:0], bus.imem_req && bus.imem_gnt};
      pa[0] <= bus.imem_addr;
      pa[1] <= pa[0];
      pa[2] <= pa[1];
      pa[3] <= pa[2];
      live  <= live + int'(bus.imem_req && bus.imem_gnt) - int'(bus.imem_rvalid);
      if (live > max_live) max_live <= live;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Pops n words with ready high; each must follow the previous by +4 (mod 256).
  task automatic consume(input int n, input logic [7:0] start);
    logic [7:0] e;
    int got;
    int waited;
    e = start;
    got = 0;
    waited = 0;
    bus.instr_ready = 1'b1;
    while (got < n && waited < 200) begin
      if (bus.instr_valid) begin
        chk("seq_instr", bus.instr, {24'b0, e});
        chk("seq_pc", {24'b0, bus.instr_pc}, {24'b0, e});
        e = e + 8'd4;
        got++;
      end
      tick();
      waited++;
    end
    chk("seq_count", got, n);
  endtask

  initial begin
    total = 0;
    bad = 0;
    lat = 1;
    rst = 1'b0;
    bus.imem_gnt = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    tick();
    tick();

    // Reset state
    chk("rst_req", bus.imem_req, 0);
    chk("rst_addr", bus.imem_addr, 0);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_instr", bus.instr, 0);
    chk("rst_pc", bus.instr_pc, 0);
    chk("rst_busy", bus.busy, 0);

    // Zero-wait memory, first word two edges after release
    rst = 1'b1;
    bus.imem_gnt = 1'b1;
    bus.instr_ready = 1'b1;
    #1;
    chk("rel_req", bus.imem_req, 1);
    chk("rel_addr", bus.imem_addr, 0);
    tick();
    chk("e1_valid", bus.instr_valid, 0);
    chk("e1_busy", bus.busy, 1);
    chk("e1_addr", bus.imem_addr, 8'h04);
    tick();
    chk("e2_valid", bus.instr_valid, 1);
    chk("e2_instr", bus.instr, 32'h0);
    chk("e2_pc", bus.instr_pc, 8'h00);
    tick();
    chk("e3_instr", bus.instr, 32'h4);
    chk("e3_pc", bus.instr_pc, 8'h04);
    tick();
    chk("e4_instr", bus.instr, 32'h8);

    // Core stall: queue fills to DEPTH and requests stop
    bus.instr_ready = 1'b0;
    repeat (10) tick();
    chk("full_req", bus.imem_req, 0);
    chk("full_valid", bus.instr_valid, 1);
    chk("full_head", bus.instr, 32'h8);
    chk("full_busy", bus.busy, 0);
    chk("full_addr", bus.imem_addr, 8'h18);
    consume(8, 8'h08);

    // Three-cycle memory latency
    rst = 1'b0;
    lat = 3;
    tick();
    rst = 1'b1;
    consume(12, 8'h00);
    chk("max_out_le4", max_live <= 4, 1);
    chk("max_out_ge3", max_live >= 3, 1);

    // Redirect with two requests in flight
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    tick();
    bus.redirect = 1'b1;
    bus.redirect_pc = 8'h2C;
    #1;
    chk("rd_req_gated", bus.imem_req, 0);
    chk("rd_busy_pre", bus.busy, 1);
    tick();
    bus.redirect = 1'b0;
    #1;
    chk("rd_valid", bus.instr_valid, 0);
    chk("rd_busy_drop", bus.busy, 1);
    chk("rd_req", bus.imem_req, 1);
    chk("rd_addr", bus.imem_addr, 8'h2C);
    consume(4, 8'h2C);

    // Redirect coinciding with a response and a pop
    rst = 1'b0;
    lat = 1;
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk("rc_head", bus.instr, 32'h0);
    bus.redirect = 1'b1;
    bus.redirect_pc = 8'h80;
    #1;
    chk("rc_req_gated", bus.imem_req, 0);
    tick();
    bus.redirect = 1'b0;
    #1;
    chk("rc_valid", bus.instr_valid, 0);
    chk("rc_instr", bus.instr, 0);
    chk("rc_busy", bus.busy, 0);
    chk("rc_addr", bus.imem_addr, 8'h80);
    chk("rc_req", bus.imem_req, 1);
    consume(3, 8'h80);

    // Address wrap past 0xFC
    bus.redirect = 1'b1;
    bus.redirect_pc = 8'hF8;
    tick();
    bus.redirect = 1'b0;
    consume(4, 8'hF8);

    // Asynchronous reset mid-stream
    rst = 1'b0;
    #1;
    chk("ar_valid", bus.instr_valid, 0);
    chk("ar_instr", bus.instr, 0);
    chk("ar_pc", bus.instr_pc, 0);
    chk("ar_req", bus.imem_req, 0);
    chk("ar_busy", bus.busy, 0);
    chk("ar_addr", bus.imem_addr, 0);
    rst = 1'b1;
    consume(3, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
